wb_arbiter: RTL

- Shares the single register-file write port among NREQ writeback requesters (ALU, LSU load return, CSR unit).
- Each requester has a valid/ready handshake. Round-robin arbitration picks one winner per cycle.
- The winner's write is registered one stage, then driven onto the register file's wen/waddr/wdata.
- A forwarding lookup port lets decode see a write that is still pending in that stage.

---
 rtl/wb_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant among NREQ requesters, one registered write stage,
// and a forwarding lookup into that stage. Define WB_ARBITER_FIXED_PRIO_EN for lowest-index-wins priority.
module wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic                 rf_wen,
   output logic [AW-1:0]        rf_waddr,
   output logic [DW-1:0]        rf_wdata,
   input  logic [AW-1:0]        fwd_addr,
   output logic                 fwd_hit,
   output logic [DW-1:0]        fwd_data
);

   localparam int PW = $clog2(NREQ);

   logic          found;
   logic [PW-1:0] win;
   logic          xfer;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;

   logic          pend_valid_q, pend_valid_d;
   logic [AW-1:0] pend_addr_q, pend_addr_d;
   logic [DW-1:0] pend_data_q, pend_data_d;

`ifdef WB_ARBITER_FIXED_PRIO_EN
   // Scan high to low so the lowest valid index is the last one written.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            found = 1'b1;
            win   = PW'(i);
         end
      end
   end
`else
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;

   // Search starts at rr_ptr and wraps; idx carries one spare bit for the wrap subtraction.
   always_comb begin
      logic [PW:0] idx;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
         if (!found && req_valid[idx[PW-1:0]]) begin
            found = 1'b1;
            win   = idx[PW-1:0];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer) rr_ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rr_ptr_q <= '0;
      else      rr_ptr_q <= rr_ptr_d;
   end
`endif

   assign xfer = found & ~stall & rst;

   always_comb begin
      req_ready = '0;
      sel_addr  = '0;
      sel_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) begin
            req_ready[i] = xfer;
            sel_addr     = req_addr[i*AW +: AW];
            sel_data     = req_data[i*DW +: DW];
         end
      end
   end

   // x0 writes are consumed but never become a pending write.
   always_comb begin
      pend_valid_d = xfer && (sel_addr != '0);
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      if (xfer) begin
         pend_addr_d = sel_addr;
         pend_data_d = sel_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
      end
   end

   assign rf_wen   = pend_valid_q;
   assign rf_waddr = pend_addr_q;
   assign rf_wdata = pend_data_q;
   assign fwd_hit  = pend_valid_q && (fwd_addr == pend_addr_q) && (fwd_addr != '0);
   assign fwd_data = pend_data_q;

endmodule
